ecg_stream_ctrl: RTL

Run controller for the ECG peak-detector datapath. It fetches a programmed number of 16-bit ECG samples from a synchronous sample memory and paces them into the detector at a fixed sample period. It resets the detector at the start of every run, and collects the detector's R-R interval results into a small FIFO with a valid/ready output. It sits between the sample RAM / host control registers and the peak-detector top level.

---
 rtl/ecg_stream_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ecg_stream_ctrl.sv
// rtl/ecg_stream_ctrl.sv - run controller pacing ECG samples into the peak detector
// Fetches samples from sample RAM at a fixed period and queues detector R-R results.
module ecg_stream_ctrl #(
  parameter int RR_FIFO_DEPTH = 4,
  parameter int CLR_CYCLES    = 2,
  parameter int DRAIN_CYCLES  = 16,
  parameter int ADDR_W        = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] num_samples_i,
  input  logic [15:0]       pace_div_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rd_data_i,
  output logic              det_rst_o,
  output logic [15:0]       det_sample_o,
  output logic              det_valid_o,
  input  logic              det_peak_i,
  input  logic [15:0]       det_rr_interval_i,
  input  logic              det_rr_valid_i,
  output logic [15:0]       rr_out_data_o,
  output logic              rr_out_valid_o,
  input  logic              rr_out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       peak_count_o,
  output logic              overflow_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int         FA         = (RR_FIFO_DEPTH > 2) ? $clog2(RR_FIFO_DEPTH) : 1;
  localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, num_q, cnt_inc;
  logic [15:0]       pace_q;
  logic              rd_q, done_q, det_valid_q, ovf_q;
  logic [15:0]       det_sample_q, peak_q;
  logic [15:0]       fifo_mem_q [RR_FIFO_DEPTH];
  logic [FA:0]       wr_ptr_q, rd_ptr_q;
  logic              idle, start_go, abort_go;
  logic              fifo_full, fifo_empty, pop, push, drop;

  assign idle     = (state_q == S_IDLE);
  assign start_go = idle && start_i;
  assign abort_go = !idle && abort_i;
  assign cnt_inc  = cnt_q + 1'b1;

  // tmr_q counts cycles spent in the current state; every transition rewinds it
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 16'd1;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (start_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (tmr_q == CLR_LAST) begin
          tmr_d   = '0;
          state_d = (num_q == '0) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_q == pace_q - 16'd2) begin
          tmr_d   = '0;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == num_q) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (tmr_q == DRAIN_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (abort_go) begin
      tmr_d   = '0;
      state_d = S_IDLE;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FA] != rd_ptr_q[FA]) &&
                      (wr_ptr_q[FA-1:0] == rd_ptr_q[FA-1:0]);
  assign pop        = !fifo_empty && rr_out_ready_i;
  // a full FIFO still accepts a result when the head leaves in the same cycle
  assign push       = !idle && det_rr_valid_i && (!fifo_full || pop);
  assign drop       = !idle && det_rr_valid_i && fifo_full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      num_q        <= '0;
      pace_q       <= 16'd3;
      rd_q         <= 1'b0;
      done_q       <= 1'b0;
      det_valid_q  <= 1'b0;
      det_sample_q <= '0;
      peak_q       <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      done_q      <= (state_q == S_DRAIN) && (tmr_q == DRAIN_LAST) && !abort_go;
      rd_q        <= (state_q == S_FETCH) && !abort_go;
      det_valid_q <= rd_q && !abort_go;
      if (rd_q && !abort_go) det_sample_q <= mem_rd_data_i;
      if (start_go) begin
        num_q    <= num_samples_i;
        pace_q   <= (pace_div_i < 16'd3) ? 16'd3 : pace_div_i;
        peak_q   <= '0;
        ovf_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (!idle && det_peak_i && peak_q != 16'hFFFF) peak_q <= peak_q + 16'd1;
        if (drop) ovf_q <= 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q[FA-1:0]] <= det_rr_interval_i;
  end

  assign mem_rd_en_o    = (state_q == S_FETCH);
  assign mem_addr_o     = cnt_q;
  assign det_rst_o      = idle || (state_q == S_CLEAR);
  assign det_sample_o   = det_sample_q;
  assign det_valid_o    = det_valid_q;
  assign rr_out_valid_o = !fifo_empty;
  assign rr_out_data_o  = fifo_empty ? 16'd0 : fifo_mem_q[rd_ptr_q[FA-1:0]];
  assign busy_o         = !idle;
  assign done_o         = done_q;
  assign peak_count_o   = peak_q;
  assign overflow_o     = ovf_q;

endmodule
